// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the 16-bit parity generator, its downstream frame
// transmitter and their benches.
//   PAR_DATA_W         : data word width shared by generator and consumer
//   PAR_EVEN / PAR_ODD : parity-sense selectors
//   tx_state_t         : frame transmitter FSM states
// ---------------------------------------------------------------------------
package parity_pkg;

    localparam int PAR_DATA_W = 16;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/bit_tick_gen.sv
// ---------------------------------------------------------------------------
// bit_tick_gen
// Serial bit-period divider. Counts 0..CLKS_PER_BIT-1 while enabled and
// flags the terminal count with tick. The count is held at zero whenever
// enable is low, so the first period after enabling is always full length.
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous reset, active high
//   enable : run the divider (low clears it)
//   tick   : high in the last cycle of each bit period
// ---------------------------------------------------------------------------
module bit_tick_gen
    import parity_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    logic [DIV_W-1:0] div_reg;

    // Combinational from the registered count only; no input-to-output path
    // other than the enable gate.
    assign tick = enable && (div_reg == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            div_reg <= '0;
        end else if (tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/parity_frame_tx.sv
// ---------------------------------------------------------------------------
// parity_frame_tx
// Accepts a data word plus its generated parity bit over a valid/ready
// handshake and sends them as a UART-style frame: start(0), data LSB first,
// parity (as supplied), stop(1). The supplied parity is re-checked against
// the data and a mismatch is flagged one cycle after accept.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous reset, active high
//   data_in    : word to send, sampled on accept
//   par_in     : parity bit from the generator, sampled on accept
//   in_valid   : upstream word valid
//   in_ready   : high exactly while idle
//   tx_out     : registered serial line, idles high
//   tx_busy    : high while a frame is in progress
//   frame_done : one-cycle pulse in the last cycle of the stop bit
//   par_err    : one-cycle pulse after accept when par_in is wrong
// ---------------------------------------------------------------------------
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int DATA_W       = PAR_DATA_W,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_ODD   = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              par_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              frame_done,
    output logic              par_err
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    tx_state_t         state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              par_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic              tx_reg;
    logic              par_err_reg;
    logic              tick;
    logic              expected_par;

    // Divider runs only while a frame is in progress, so it restarts from 0
    // on the edge that enters START.
    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .enable(state_reg != IDLE),
        .tick  (tick)
    );

    assign expected_par = (^data_in) ^ PARITY_ODD;

    // Handshake and status derive from the registered state only, keeping
    // in_valid out of any combinational path to in_ready.
    assign in_ready   = (state_reg == IDLE);
    assign tx_busy    = (state_reg != IDLE);
    assign frame_done = (state_reg == STOP) && tick;
    assign tx_out     = tx_reg;
    assign par_err    = par_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            par_reg     <= 1'b0;
            bit_cnt_reg <= '0;
            tx_reg      <= 1'b1;
            par_err_reg <= 1'b0;
        end else begin
            par_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (in_valid) begin
                        shift_reg   <= data_in;
                        par_reg     <= par_in;
                        par_err_reg <= (expected_par != par_in);
                        bit_cnt_reg <= '0;
                        tx_reg      <= 1'b0;
                        state_reg   <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        bit_cnt_reg <= '0;
                        tx_reg      <= shift_reg[0];
                        state_reg   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt_reg == CNT_LAST) begin
                            tx_reg    <= par_reg;
                            state_reg <= PARITY;
                        end else begin
                            // Next bit is presented on the same edge it is
                            // shifted into position 0.
                            shift_reg   <= shift_reg >> 1;
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            tx_reg      <= shift_reg[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx_reg    <= 1'b1;
                        state_reg <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        tx_reg    <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_tx
// Stimulus issues words through the handshake; a cycle model predicts when
// words are accepted and pushes each expected frame into a queue. A monitor
// checks handshake/status timing every cycle and decodes the serial line,
// popping and comparing a frame whenever the DUT signals frame_done.
// ---------------------------------------------------------------------------
module tb_parity_frame_tx;
    import parity_pkg::*;

    localparam int DW        = PAR_DATA_W;
    localparam int CLKS      = 4;
    localparam bit POL_ODD   = PAR_EVEN;
    localparam int NBITS     = DW + 3;
    localparam int FRAME_CYC = NBITS * CLKS;

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
        logic          err;
    } frame_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          par_in;
    logic          in_valid;
    logic          in_ready;
    logic          tx_out;
    logic          tx_busy;
    logic          frame_done;
    logic          par_err;

    parity_frame_tx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(CLKS),
        .PARITY_ODD  (POL_ODD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .par_in    (par_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_out    (tx_out),
        .tx_busy   (tx_busy),
        .frame_done(frame_done),
        .par_err   (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;
    bit final_req = 0;
    bit final_done = 0;

    // Reference model state
    frame_t exp_q[$];
    bit     m_ready = 1'b1;
    int     m_rem = 0;
    bit     m_pe = 1'b0;
    int     epoch = 0;

    function automatic logic ref_par(input logic [DW-1:0] d);
        int ones = 0;
        for (int k = 0; k < DW; k++) if (d[k]) ones++;
        return ((ones % 2) == 1) ^ POL_ODD;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: a frame occupies FRAME_CYC cycles after accept, then one
    // idle cycle with in_ready high before the next accept can happen.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_ready = 1'b1;
                m_rem   = 0;
                m_pe    = 1'b0;
                exp_q.delete();
                epoch++;
            end else if (m_ready && in_valid) begin
                frame_t f;
                f.data  = data_in;
                f.par   = par_in;
                f.err   = (par_in != ref_par(data_in));
                exp_q.push_back(f);
                m_ready = 1'b0;
                m_rem   = FRAME_CYC;
                m_pe    = f.err;
            end else begin
                m_pe = 1'b0;
                if (!m_ready) begin
                    m_rem--;
                    if (m_rem == 0) m_ready = 1'b1;
                end
            end
        end
    end

    // Monitor: per-cycle status checks plus serial-line frame decoder.
    initial begin
        bit            cap = 0;
        int            c = 0;
        int            nb = 0;
        int            seen_epoch = 0;
        logic [NBITS-1:0] bits = '0;
        forever begin
            @(negedge clk);
            if (check_en) begin
                check_val("in_ready", in_ready, m_ready);
                check_val("tx_busy", tx_busy, !m_ready);
                check_val("frame_done_timing", frame_done, (!m_ready && m_rem == 1));
                check_val("par_err", par_err, m_pe);
                if (m_ready) check_val("tx_idle_high", tx_out, 1'b1);

                if (epoch != seen_epoch) begin
                    seen_epoch = epoch;
                    cap = 0;
                end
                if (!cap && tx_out == 1'b0) begin
                    cap = 1;
                    c   = 0;
                    nb  = 0;
                end
                if (cap) begin
                    if (nb < NBITS && c == nb * CLKS + CLKS / 2) begin
                        bits[nb] = tx_out;
                        nb++;
                    end
                    if (frame_done) begin
                        check_val("frame_length", c, FRAME_CYC - 1);
                        check_val("bits_sampled", nb, NBITS);
                        if (exp_q.size() == 0) begin
                            check_val("frame_expected", 0, 1);
                        end else begin
                            frame_t e;
                            logic [DW-1:0] got;
                            e = exp_q.pop_front();
                            for (int k = 0; k < DW; k++) got[k] = bits[k + 1];
                            check_val("start_bit", bits[0], 1'b0);
                            check_val("data_bits", got, e.data);
                            check_val("parity_bit", bits[DW + 1], e.par);
                            check_val("stop_bit", bits[DW + 2], 1'b1);
                            $display("frame data=0x%04h par=%0b err_expected=%0b", got, bits[DW + 1], e.err);
                        end
                        cap = 0;
                    end else if (c > FRAME_CYC + 4) begin
                        check_val("frame_runaway", c, FRAME_CYC - 1);
                        cap = 0;
                    end
                    c++;
                end else if (frame_done) begin
                    check_val("spurious_frame_done", frame_done, 1'b0);
                end

                if (final_req && !final_done) begin
                    check_val("queue_drained", 32'(exp_q.size()), 0);
                    final_done = 1;
                end
            end
        end
    end

    // Present a word and wait (bounded) until the handshake completes.
    task automatic send(input logic [DW-1:0] d, input logic p, input bit hold);
        int n = 0;
        bit r;
        data_in  = d;
        par_in   = p;
        in_valid = 1'b1;
        do begin
            r = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (n > 300) begin
                $display("FAIL handshake_timeout: in_ready not seen for word 0x%04h", d);
                $fatal(1, "handshake timeout");
            end
        end while (!r);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        rst      = 1'b1;
        data_in  = '0;
        par_in   = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_en = 1;
        in_valid = 1'b1;       // ignored while reset is high
        idle(2);
        in_valid = 1'b0;
        rst = 1'b0;
        idle(2);

        // Single word with correct parity
        send(16'h0001, 1'b1, 0);
        idle(80);

        // Wrong parity: error flagged, supplied bit still sent
        send(16'h0003, 1'b1, 0);
        idle(80);

        // Back-to-back with in_valid held high
        send(16'h0005, 1'b0, 1);
        send(16'h0006, 1'b0, 0);
        idle(80);

        // Input changes while busy must not affect the frame
        send(16'h0007, 1'b1, 0);
        data_in  = 16'hFFFF;
        par_in   = 1'b0;
        in_valid = 1'b1;
        idle(10);
        in_valid = 1'b0;
        idle(70);

        // Reset mid-DATA, with in_valid asserted during the reset cycle
        send(16'hA5C3, ref_par(16'hA5C3), 0);
        idle(29);
        rst      = 1'b1;
        in_valid = 1'b1;
        data_in  = 16'h1234;
        idle(1);
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(5);

        // Sweep with correct parity
        for (int w = 0; w < 8; w++) begin
            d = DW'(w);
            send(d, ref_par(d), 0);
        end
        idle(80);

        // Randomised words, occasional bad parity, mixed gaps and held valid
        for (int i = 0; i < 20; i++) begin
            bit hold;
            d    = DW'($urandom);
            hold = ($urandom_range(0, 1) == 1);
            send(d, ref_par(d) ^ ($urandom_range(0, 3) == 0), hold);
            if (!hold) idle($urandom_range(0, 3));
        end
        in_valid = 1'b0;
        idle(90);

        final_req = 1;
        for (int n = 0; n < 10 && !final_done; n++) idle(1);
        if (!final_done) begin
            $display("FAIL final_check_timeout: monitor did not respond");
            $fatal(1, "final check timeout");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Downstream stage of the 16-bit parity generator. Accepts a data word and its generated parity bit through a valid/ready handshake and serialises them onto a single line as a UART-style frame: start, data LSB-first, parity, stop. It also re-checks the supplied parity against the data and flags mismatches, so a faulty or mis-wired generator is caught at the consumer.

Parameters:
DATA_W, 16, width of the data word; must match the generator.
CLKS_PER_BIT, 4, clock cycles per serial bit; must be at least 2.
PARITY_ODD, 0, 0 means the expected par_in is the XOR of data_in (even parity); 1 means its inverse (odd parity).

Ports:
clk  input  1  single system clock; all logic is rising-edge.
rst  input  1  synchronous reset, active-high.
data_in  input  DATA_W  word to send; sampled on accept.
par_in  input  1  parity bit from the generator (par_out); sampled on accept.
in_valid  input  1  upstream holds data_in and par_in valid.
in_ready  output  1  block can accept a word; equals 1 exactly when state is IDLE.
tx_out  output  1  serial line; idles high.
tx_busy  output  1  high whenever a frame is in progress (state is not IDLE).
frame_done  output  1  one-cycle pulse in the last cycle of STOP.
par_err  output  1  one-cycle pulse, the cycle after accept, if par_in does not equal the expected parity.

Behaviour:
- Reset: synchronous to clk. While rst is high, state goes to IDLE and the divider and bit counters clear. Outputs: tx_out=1, tx_busy=0, frame_done=0, par_err=0, in_ready=1. in_valid is ignored in any cycle where rst is high.
- Accept: happens on a clk edge with in_valid=1, in_ready=1 and rst=0.
  - Latch data_in into the shift register and par_in into a parity register.
  - Enter START with the divider at 0.
  - in_ready drops the next cycle.
  - No combinational path from in_valid to in_ready.
- Parity check: the expected bit is (XOR of data_in) XOR PARITY_ODD, computed on the accepted word. par_err is registered and pulses exactly one cycle after accept on mismatch. The frame is still sent using the supplied par_in unchanged.
- Bit timing:
  - The divider counts 0 to CLKS_PER_BIT-1; its terminal count (tick) advances the FSM.
  - Each serial bit is held for exactly CLKS_PER_BIT cycles.
  - tx_out is registered and changes on the edge that enters each state or bit.
- FSM:
  - IDLE: tx_out=1. On accept go to START.
  - START: tx_out=0. On tick go to DATA with bit_cnt=0.
  - DATA: tx_out = shift register bit 0. On tick, shift right and increment bit_cnt. When bit_cnt = DATA_W-1 on tick, go to PARITY.
  - PARITY: tx_out = latched par_in. On tick go to STOP.
  - STOP: tx_out=1. On tick, pulse frame_done in this same cycle and go to IDLE.
- Latency:
  - The first start-bit cycle is the cycle after accept.
  - A frame lasts (DATA_W+3)*CLKS_PER_BIT cycles; with defaults, 76.
  - in_ready returns high in the cycle after frame_done.
  - Minimum spacing between back-to-back accepts is therefore 77 cycles.
- While busy: changes on data_in, par_in and in_valid have no effect; the latched word is sent unchanged.
- Reset mid-frame: the frame is aborted. tx_out=1 in the cycle after the reset edge. No frame_done is produced for the aborted frame, and no partial state is kept.
- bit_cnt is sized to clog2(DATA_W). The divider is sized to clog2(CLKS_PER_BIT). Neither counter is allowed to wrap past its terminal value.

Decomposition:
- Shared package parity_pkg holds:
  - tx_state_t enum: IDLE, START, DATA, PARITY, STOP.
  - PAR_DATA_W = 16, shared with the generator and its bench.
  - Parity-sense constants: PAR_EVEN = 0, PAR_ODD = 1.
- One sub-module: bit_tick_gen.
  - Inputs: clk, rst, enable.
  - Output: tick.
  - Parameter: CLKS_PER_BIT.
  - The counter clears whenever enable is low; the FSM holds enable low in IDLE.

Test Plan:
- Reset, then data_in=16'h0001, par_in=1, in_valid for one cycle -> tx_out sampled mid-bit reads 0, 1, fifteen 0s, 1 (parity), 1 (stop). frame_done pulses 76 cycles after accept; par_err stays 0.
- data_in=16'h0003, par_in=1, PARITY_ODD=0 -> par_err pulses once, one cycle after accept. The parity bit sent on the line is 1.
- in_valid held high with words 16'h0005 then 16'h0006 -> second accept occurs exactly 77 cycles after the first; two complete frames with no gap beyond one idle cycle.
- Accept 16'h0007, then change data_in to 16'hFFFF while busy -> the line carries 16'h0007 bits; in_ready stays 0 until after frame_done.
- Assert rst for one cycle mid-DATA (cycle 30 after accept) -> tx_out=1, tx_busy=0, in_ready=1 the next cycle; no frame_done.
- Sweep data_in 16'h0000 to 16'h0007 with correct generator parity -> par_err never asserts; each frame's parity bit equals the XOR of its data.
